// File: rtl/isa_pkg.sv
// Shared ISA types: the machine word and the entry carried from fetch to decode.
package isa_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t instr;
      logic  pred_taken;
      word_t pred_pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Bundle of the fetch/decode queue signals, with a block-side (fq) and a bench-side (tb) view.
interface fetch_decode_queue_if
   import isa_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic CLK,
   input logic RST
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             flush;
   logic             enq_valid;
   logic             enq_ready;
   word_t            enq_pc;
   word_t            enq_instr;
   logic             enq_pred_taken;
   word_t            enq_pred_pc;
   logic             deq_valid;
   logic             deq_ready;
   word_t            deq_pc;
   word_t            deq_instr;
   logic             deq_pred_taken;
   word_t            deq_pred_pc;
   logic [CNT_W-1:0] count;

   modport fq (
      input  CLK, RST, flush,
      input  enq_valid, enq_pc, enq_instr, enq_pred_taken, enq_pred_pc,
      output enq_ready,
      output deq_valid, deq_pc, deq_instr, deq_pred_taken, deq_pred_pc, count,
      input  deq_ready
   );

   modport tb (
      input  CLK, RST,
      output flush,
      output enq_valid, enq_pc, enq_instr, enq_pred_taken, enq_pred_pc,
      input  enq_ready,
      input  deq_valid, deq_pc, deq_instr, deq_pred_taken, deq_pred_pc, count,
      output deq_ready
   );

endinterface

// File: rtl/fetch_decode_queue.sv
// In-order fetch-to-decode instruction queue with single-cycle misprediction flush.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_DECODE_QUEUE_BYPASS_EN.
module fetch_decode_queue
   import isa_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  word_t            enq_pc,
   input  word_t            enq_instr,
   input  logic             enq_pred_taken,
   input  word_t            enq_pred_pc,
   output logic             deq_valid,
   input  logic             deq_ready,
   output word_t            deq_pc,
   output word_t            deq_instr,
   output logic             deq_pred_taken,
   output word_t            deq_pred_pc,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic         w_empty;
   logic         w_full;
   logic         w_q_valid;
   logic         w_bypass;
   logic         w_enq_fire;
   logic         w_deq_fire;
   fetch_entry_t w_enq_entry;
   fetch_entry_t w_head_entry;
   fetch_entry_t w_deq_entry;

   assign w_enq_entry = '{pc: enq_pc, instr: enq_instr, pred_taken: enq_pred_taken, pred_pc: enq_pred_pc};

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign enq_ready = !w_full && !flush;
   assign w_q_valid = !w_empty && !flush;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
   assign w_bypass = w_empty && enq_valid && deq_ready && !flush;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed entry is consumed on the spot, so it is neither written nor counted.
   assign w_enq_fire = enq_valid && enq_ready && !w_bypass;
   assign w_deq_fire = w_q_valid && deq_ready;

   assign w_head_entry = (!w_empty && r_valid[r_head]) ? r_mem[r_head] : '0;
   assign w_deq_entry  = w_bypass ? w_enq_entry : w_head_entry;

   assign deq_valid      = w_q_valid || w_bypass;
   assign deq_pc         = w_deq_entry.pc;
   assign deq_instr      = w_deq_entry.instr;
   assign deq_pred_taken = w_deq_entry.pred_taken;
   assign deq_pred_pc    = w_deq_entry.pred_pc;
   assign count          = r_count;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         // Enqueue and dequeue never target the same slot: that needs empty or full.
         if (w_enq_fire) begin
            r_tail          <= r_tail + PTR_W'(1);
            r_valid[r_tail] <= 1'b1;
         end
         if (w_deq_fire) begin
            r_head          <= r_head + PTR_W'(1);
            r_valid[r_head] <= 1'b0;
         end
         case ({w_enq_fire, w_deq_fire})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (w_enq_fire) begin
         r_mem[r_tail] <= w_enq_entry;
      end
   end

   a_count_bound: assert property (@(posedge CLK) disable iff (RST) r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed plus random checks of fetch_decode_queue against a queue-based reference model.
module tb_fetch_decode_queue;
   import isa_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        flush = 1'b0;
   logic        enq_valid = 1'b0;
   logic        deq_ready = 1'b0;
   logic        enq_pred_taken = 1'b0;
   logic [31:0] enq_pc = '0;
   logic [31:0] enq_instr = '0;
   logic [31:0] enq_pred_pc = '0;
   logic        enq_ready;
   logic        deq_valid;
   logic        deq_pred_taken;
   logic [31:0] deq_pc;
   logic [31:0] deq_instr;
   logic [31:0] deq_pred_pc;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_entry_t model_q[$];

   always #5 CLK = ~CLK;

   fetch_decode_queue #(.DEPTH(4)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .flush          (flush),
      .enq_valid      (enq_valid),
      .enq_ready      (enq_ready),
      .enq_pc         (enq_pc),
      .enq_instr      (enq_instr),
      .enq_pred_taken (enq_pred_taken),
      .enq_pred_pc    (enq_pred_pc),
      .deq_valid      (deq_valid),
      .deq_ready      (deq_ready),
      .deq_pc         (deq_pc),
      .deq_instr      (deq_instr),
      .deq_pred_taken (deq_pred_taken),
      .deq_pred_pc    (deq_pred_pc),
      .count          (count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, check just after, update the model on the rising edge.
   task automatic step(input logic f, input logic ev, input logic dr, input logic [31:0] pc);
      fetch_entry_t e;
      fetch_entry_t h;
      logic         byp;
      logic         exp_rdy;
      logic         exp_val;
      logic         enq_fire;
      logic         deq_fire;
      e.pc         = pc;
      e.instr      = $urandom;
      e.pred_taken = 1'($urandom_range(1));
      e.pred_pc    = $urandom;
      flush          = f;
      enq_valid      = ev;
      deq_ready      = dr;
      enq_pc         = e.pc;
      enq_instr      = e.instr;
      enq_pred_taken = e.pred_taken;
      enq_pred_pc    = e.pred_pc;
      #1;
      h = '0;
      if (model_q.size() != 0) h = model_q[0];
      byp = 1'b0;
`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
      byp = (model_q.size() == 0) && ev && dr && !f;
      if (byp) h = e;
`endif
      exp_rdy = (model_q.size() < 4) && !f;
      exp_val = ((model_q.size() != 0) && !f) || byp;
      chk("enq_ready", 32'(enq_ready), 32'(exp_rdy));
      chk("deq_valid", 32'(deq_valid), 32'(exp_val));
      chk("deq_pc", deq_pc, h.pc);
      chk("deq_instr", deq_instr, h.instr);
      chk("deq_pred_taken", 32'(deq_pred_taken), 32'(h.pred_taken));
      chk("deq_pred_pc", deq_pred_pc, h.pred_pc);
      chk("count", 32'(count), model_q.size());
      enq_fire = ev && exp_rdy && !byp;
      deq_fire = exp_val && dr;
      $display("t=%0t rst=%b flush=%b enq=%b pc=%h deq=%b pc=%h cnt=%0d",
               $time, RST, f, ev && exp_rdy, pc, deq_fire, h.pc, model_q.size());
      @(posedge CLK);
      if (RST || f) begin
         model_q.delete();
      end else begin
         if (deq_fire && !byp) void'(model_q.pop_front());
         if (enq_fire) model_q.push_back(e);
      end
      @(negedge CLK);
   endtask

   initial begin
      @(negedge CLK);
      step(1'b0, 1'b1, 1'b0, 32'h0000_0abc);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      RST = 1'b0;

      // asynchronous reset with three entries held
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h20 + 32'(i * 4));
      RST = 1'b1;
      #1;
      chk("async_rst deq_valid", 32'(deq_valid), 32'd0);
      chk("async_rst count", 32'(count), 32'd0);
      chk("async_rst enq_ready", 32'(enq_ready), 32'd1);
      chk("async_rst deq_pc", deq_pc, 32'd0);
      model_q.delete();
      @(negedge CLK);
      RST = 1'b0;
      step(1'b0, 1'b1, 1'b0, 32'h100);
      step(1'b0, 1'b0, 1'b1, 32'h0);

      // fill to full, drop a fifth, drain in order
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'(i * 4));
      step(1'b0, 1'b1, 1'b0, 32'h10);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0);

      // streaming: ten entries through a four-entry ring
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 32'h200 + 32'(i * 4));
      step(1'b0, 1'b0, 1'b1, 32'h0);

      // full queue with simultaneous dequeue refuses the enqueue
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h300 + 32'(i * 4));
      step(1'b0, 1'b1, 1'b1, 32'h3f0);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h0);

      // flush drops held entries and the concurrent enqueue
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h400 + 32'(i * 4));
      step(1'b1, 1'b1, 1'b1, 32'h500);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h800);
      step(1'b0, 1'b0, 1'b1, 32'h0);

      // empty queue with enqueue and dequeue together (bypass when enabled)
      step(1'b0, 1'b1, 1'b1, 32'h40);
      step(1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(15) == 0), ($urandom_range(3) != 0), ($urandom_range(2) != 0),
              $urandom & 32'hffff_fffc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Small in-order instruction queue between the fetch stage and the decode stage.
- Decouples fetch from decode stalls: fetch enqueues {pc, instr, predicted_outcome, predicted_pc} each cycle it produces an instruction, and decode dequeues with a valid/ready handshake.
- On a branch misprediction the queue is flushed in one cycle so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, 2..16.
- PTR_W, $clog2(DEPTH), head/tail pointer width; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- flush  input  1  misprediction flush from branch resolution.
- enq_valid  input  1  fetch presents an instruction.
- enq_ready  output  1  queue can accept this cycle.
- enq_pc  input  32  word_t PC of the fetched instruction.
- enq_instr  input  32  word_t instruction word.
- enq_pred_taken  input  1  fetch prediction for this instruction.
- enq_pred_pc  input  32  word_t predicted next PC.
- deq_valid  output  1  head entry is valid.
- deq_ready  input  1  decode accepts the head entry.
- deq_pc  output  32  head PC.
- deq_instr  output  32  head instruction.
- deq_pred_taken  output  1  head prediction.
- deq_pred_pc  output  32  head predicted PC.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, RST=1): head=0, tail=0, count=0, storage valid bits cleared.
  - Outputs during reset: deq_valid=0, deq_pc=0, deq_instr=0, deq_pred_taken=0, deq_pred_pc=0, enq_ready=1.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Handshakes:
  - Enqueue fires when enq_valid && enq_ready.
  - Dequeue fires when deq_valid && deq_ready.
- enq_ready = (count != DEPTH) && !flush. It does not depend on deq_ready, so there is no combinational path between the deq and enq sides. A full queue therefore refuses an enqueue even when a dequeue fires in the same cycle.
- Dequeue outputs:
  - deq_valid = (count != 0) && !flush.
  - deq_* is the head entry, read combinationally from the register array.
  - When count==0, deq_* is driven 0.
- Latency:
  - An enqueued entry is visible at deq the cycle after its enqueue edge.
  - Decode-side throughput is one instruction per cycle.
- Pointers:
  - tail advances on enqueue; head advances on dequeue.
  - Both wrap modulo DEPTH with natural PTR_W overflow.
- count update:
  - enqueue only: +1.
  - dequeue only: -1.
  - both: unchanged.
  - neither: unchanged.
- Ordering: strict FIFO. An entry's four fields always travel together.
- Flush (highest priority):
  - On the edge where flush=1, head=tail=0 and count=0.
  - No enqueue or dequeue is recognised in a flush cycle; enq_ready and deq_valid are both 0 during it.
  - The correct-path instruction arrives from fetch on a later cycle.
- Underflow/overflow: impossible by construction. An assertion (simulation only) checks count <= DEPTH.

Optional Feature:
- Macro: FETCH_DECODE_QUEUE_BYPASS_EN.
- Defined:
  - When count==0, enq_valid=1, deq_ready=1 and flush=0, the enq fields pass combinationally to deq_* with deq_valid=1.
  - The entry is consumed in the same cycle and not written; count stays 0.
  - enq_ready is unchanged.
- Undefined: no bypass; minimum latency is 1 cycle, as in Behaviour.

Decomposition:
- isa_pkg (existing) supplies word_t.
- Add fetch_entry_t to isa_pkg: packed struct {word_t pc; word_t instr; logic pred_taken; word_t pred_pc;}.
- Storage is an array of fetch_entry_t.
- No sub-module: pointer/count logic and the storage array stay in one module.
- A fetch_decode_queue_if interface with fq (block) and tb modports carries the ports above.

Test Plan:
- Reset: assert RST mid-cycle with 3 entries held → deq_valid=0, count=0, enq_ready=1 immediately; after release, enqueue PC 0x100 → next cycle deq_pc=0x100.
- Fill: deq_ready=0, enqueue PCs 0x0,0x4,0x8,0xC → count=4, enq_ready=0; a fifth enq_valid (PC 0x10) is dropped; dequeue order is 0x0,0x4,0x8,0xC.
- Streaming: enq_valid=deq_ready=1 continuously for 10 PCs 0x200..0x224 → count stays 1 after the first cycle, in-order output, pointers wrap twice with no loss.
- Full with simultaneous deq: count=4, deq_ready=1, enq_valid=1 → dequeue fires, enqueue refused, count=3 next cycle.
- Flush: 3 entries held plus flush=1 with enq_valid=1 (PC 0x500) → next cycle count=0, deq_valid=0, 0x500 never appears; a following enqueue of PC 0x800 appears at deq one cycle later.
- Bypass (macro defined): empty queue, enq_valid=deq_ready=1 with PC 0x40 → same cycle deq_valid=1, deq_pc=0x40, count stays 0. Macro undefined: deq_valid rises one cycle later.
